divider: RTL and testbench

Sequential restoring divider and the inverse of the team's shift-add multiplier. It accepts a 16-bit dividend and an 8-bit divisor on a `start` pulse. It retires one quotient bit per clock over 16 iterations, then presents the quotient and remainder with a one-cycle `ready` strobe. It is used alongside the multiplier in the arithmetic practice datapath, with the same start/ready handshake style.

---
 rtl/divider.sv | 158 +++++++++++++++
 tb/tb_divider.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential restoring divider: 16-bit / 8-bit unsigned, one quotient bit per clock, ready pulse on completion.
// Optional feature macro: DIVIDER_DIV0_EN adds the registered div0 output flag.
module divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder
`ifdef DIVIDER_DIV0_EN
    ,
    output logic        div0
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] q_r;
    logic [7:0]  d_r;
    logic [7:0]  dvd_lo_r;
    logic [8:0]  r_r;
    logic [4:0]  count_r;
    logic        ready_r;
    logic [15:0] quotient_r;
    logic [7:0]  remainder_r;

    logic [8:0]  r_shift_s;
    logic [8:0]  r_next_s;
    logic [15:0] q_next_s;
    logic        last_s;
    logic        d_zero_s;

    // One restoring iteration: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        r_shift_s = {r_r[7:0], q_r[15]};
        r_next_s  = r_shift_s;
        q_next_s  = {q_r[14:0], 1'b0};
        if (r_shift_s >= {1'b0, d_r}) begin
            r_next_s = r_shift_s - {1'b0, d_r};
            q_next_s = {q_r[14:0], 1'b1};
        end else begin
            r_next_s = r_shift_s;
            q_next_s = {q_r[14:0], 1'b0};
        end
        last_s   = (state_r == RUN) && (count_r == 5'd15);
        d_zero_s = (d_r == 8'd0);
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Working registers: capture operands on accept, iterate while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r      <= 16'd0;
            d_r      <= 8'd0;
            dvd_lo_r <= 8'd0;
            r_r      <= 9'd0;
            count_r  <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        q_r      <= dividend;
                        d_r      <= divisor;
                        dvd_lo_r <= dividend[7:0];
                        r_r      <= 9'd0;
                        count_r  <= 5'd0;
                    end
                end
                RUN: begin
                    q_r     <= q_next_s;
                    r_r     <= r_next_s;
                    count_r <= count_r + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers load on the final-iteration edge; a zero divisor forces fixed values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r     <= 1'b0;
            quotient_r  <= 16'd0;
            remainder_r <= 8'd0;
        end else begin
            ready_r <= last_s;
            if (last_s) begin
                if (d_zero_s) begin
                    quotient_r  <= 16'hFFFF;
                    remainder_r <= dvd_lo_r;
                end else begin
                    quotient_r  <= q_next_s;
                    remainder_r <= r_next_s[7:0];
                end
            end
        end
    end

    assign ready     = ready_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;

`ifdef DIVIDER_DIV0_EN
    logic div0_r;

    // Divide-by-zero flag, held alongside the results.
    always_ff @(posedge clk) begin
        if (reset) begin
            div0_r <= 1'b0;
        end else if (last_s) begin
            div0_r <= d_zero_s;
        end
    end

    assign div0 = div0_r;
`endif

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases, continuous-start throughput, mid-run reset, random operands.
module tb_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
`ifdef DIVIDER_DIV0_EN
    logic        div0;
`endif

    int tests;
    int fails;

    divider dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIVIDER_DIV0_EN
        ,
        .div0      (div0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero convention.
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r);
        if (b == 8'd0) begin
            q = 16'hFFFF;
            r = a[7:0];
        end else begin
            q = 16'(int'(a) / int'(b));
            r = 8'(int'(a) % int'(b));
        end
    endfunction

    task automatic run_check(input logic [15:0] a, input logic [7:0] b, input bit exact_lat);
        logic [15:0] eq;
        logic [7:0]  er;
        int          lat;
        model(a, b, eq, er);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat = 0;
        for (int i = 2; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = i;
                break;
            end
        end
        if (exact_lat) chk("latency", lat, 17);
        else chk("ready_seen", (lat != 0), 1);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
`ifdef DIVIDER_DIV0_EN
        chk("div0", div0, (b == 8'd0));
`endif
        if (b != 8'd0) begin
            chk("identity", int'(quotient) * int'(b) + int'(remainder), a);
            chk("rem_lt_div", (remainder < b), 1);
        end
        @(posedge clk); #1;
        chk("ready_pulse_width", ready, 0);
        chk("quotient_hold", quotient, eq);
    endtask

    logic [15:0] ops_a [0:71];
    logic [7:0]  ops_b [0:71];
    int          results;
    int          last_ready;
    bit          spurious;

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", ready, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
`ifdef DIVIDER_DIV0_EN
        chk("reset_div0", div0, 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        run_check(16'd100, 8'd7, 1'b1);
        run_check(16'd65535, 8'd255, 1'b1);
        run_check(16'd5, 8'd9, 1'b1);
        run_check(16'h1234, 8'd0, 1'b1);
        run_check(16'd0, 8'd1, 1'b1);
        run_check(16'd65535, 8'd1, 1'b1);

        // Start held high: accepts every 18 cycles, each result from its accept-cycle operands.
        results    = 0;
        last_ready = -1;
        for (int k = 0; k < 72; k++) begin
            ops_a[k] = 16'($urandom);
            ops_b[k] = 8'($urandom_range(0, 255));
            dividend = ops_a[k];
            divisor  = ops_b[k];
            start    = 1'b1;
            @(posedge clk); #1;
            if (ready) begin
                logic [15:0] eq;
                logic [7:0]  er;
                chk("stream_ready_edge", k, 16 + 18 * results);
                if (k >= 16) begin
                    model(ops_a[k-16], ops_b[k-16], eq, er);
                    chk("stream_quotient", quotient, eq);
                    chk("stream_remainder", remainder, er);
                end
                results++;
                last_ready = k;
            end
        end
        start = 1'b0;
        chk("stream_results", results, 4);
        @(posedge clk); #1;

        // Reset 8 cycles into RUN, with start also high during reset.
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        chk("midreset_ready", ready, 0);
        chk("midreset_quotient", quotient, 0);
        chk("midreset_remainder", remainder, 0);
`ifdef DIVIDER_DIV0_EN
        chk("midreset_div0", div0, 0);
`endif
        reset = 1'b0;
        start = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ready) spurious = 1'b1;
        end
        chk("no_ready_after_reset", spurious, 0);
        run_check(16'd200, 8'd3, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            run_check(16'($urandom), 8'($urandom_range(1, 255)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
